// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: word-organised memory with byte strobes, programmable wait states
// and a two-cycle ERROR response for out-of-range, misaligned or oversized accesses.
module ahb_sram_slave #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    Hclk,
    input  logic                    Hresetn,
    input  logic                    Hsel,
    input  logic [ADDR_WIDTH-1:0]   Haddr,
    input  logic                    HWrite,
    input  logic [2:0]              Hsize,
    input  logic [2:0]              Hburst,
    input  logic [1:0]              Htrans,
    input  logic [DATA_WIDTH/8-1:0] Hstrb,
    input  logic [DATA_WIDTH-1:0]   HWdata,
    input  logic                    Hready,
    output logic                    Hreadyout,
    output logic [1:0]              Hresp,
    output logic [DATA_WIDTH-1:0]   HRdata
);

    localparam int                    STRB_W    = DATA_WIDTH / 8;
    localparam int                    LANE_SH   = $clog2(STRB_W);
    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * STRB_W);
    localparam logic [3:0]            WS        = 4'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    function automatic logic access_err(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [2:0]            size);
        logic [ADDR_WIDTH-1:0] off;
        logic [ADDR_WIDTH-1:0] mask;
        off  = addr - BASE_ADDR;
        mask = ~({ADDR_WIDTH{1'b1}} << size);
        return (addr < BASE_ADDR) || (off >= MEM_BYTES) ||
               ((addr & mask) != '0) || (size > 3'(LANE_SH));
    endfunction

    state_t                  state, state_nxt;
    logic [3:0]              wcnt, wcnt_nxt;
    logic                    accept, launch, acc_bad;
    logic [ADDR_WIDTH-1:0]   off_p0;
    logic [IDX_W-1:0]        idx_p1;
    logic                    write_p1;
    logic [STRB_W-1:0]       strb_p1;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   rd_hold;
    logic                    rd_live;
    logic                    unused_bits;

    assign accept      = Hsel & Hready & Htrans[1];
    assign acc_bad     = access_err(Haddr, Hsize);
    assign off_p0      = Haddr - BASE_ADDR;
    assign unused_bits = ^{Hburst, Htrans[0], off_p0};

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        launch    = 1'b0;
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        unique case (state)
            S_WAIT: begin
                Hreadyout = 1'b0;
                wcnt_nxt  = wcnt - 4'd1;
                if (wcnt == 4'd1)
                    state_nxt = S_DATA;
            end
            S_ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 2'b01;
                state_nxt = S_ERR2;
            end
            default: begin
                // IDLE, DATA and ERR2 all close a data phase and may take the next address phase
                if (state == S_ERR2)
                    Hresp = 2'b01;
                launch = accept;
                if (!accept)
                    state_nxt = S_IDLE;
                else if (acc_bad)
                    state_nxt = S_ERR1;
                else if (WS != 4'd0) begin
                    state_nxt = S_WAIT;
                    wcnt_nxt  = WS;
                end else
                    state_nxt = S_DATA;
            end
        endcase
    end

    assign rd_live = (state == S_DATA) && !write_p1;
    assign HRdata  = rd_live ? mem[idx_p1] : rd_hold;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state   <= S_IDLE;
            wcnt    <= '0;
            rd_hold <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (rd_live)
                rd_hold <= mem[idx_p1];
        end
    end

    // address phase -> data phase
    always_ff @(posedge Hclk) begin
        if (launch) begin
            idx_p1   <= off_p0[LANE_SH +: IDX_W];
            write_p1 <= HWrite;
            strb_p1  <= Hstrb;
        end
    end

    // data phase: write commits at the closing edge of the DATA cycle
    always_ff @(posedge Hclk) begin
        if (state == S_DATA && write_p1) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (strb_p1[i])
                    mem[idx_p1][8*i +: 8] <= HWdata[8*i +: 8];
            end
        end
    end

endmodule
